// File: rtl/eth_f_hw_avmm_pkg.sv
// Shared definitions for the AVMM host arbiter: FSM encodings, default
// timeout response data and an index-width helper.
package eth_f_hw_avmm_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CMD  = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'h12345678;

  // Index width that stays legal (>=1 bit) when there is only one host.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eth_f_hw_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr,
// wrapping modulo NUM_HOSTS. Returns one-hot grant, its index and a valid flag.
module eth_f_hw_rr_pick
  import eth_f_hw_avmm_pkg::*;
#(
  parameter int NUM_HOSTS = 2,
  localparam int IW = idx_width(NUM_HOSTS)
) (
  input  logic [NUM_HOSTS-1:0] req,
  input  logic [IW-1:0]        ptr,
  output logic [NUM_HOSTS-1:0] grant,
  output logic [IW-1:0]        grant_idx,
  output logic                 valid
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // The sum is one bit wider than the index so ptr+k never overflows
  // before the modulo correction.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NUM_HOSTS; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_HOSTS))
        sum = sum - (IW+1)'(NUM_HOSTS);
      cand = sum[IW-1:0];
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        grant_idx = cand;
      end
    end
    if (valid)
      grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/eth_f_hw_avmm_host_arb.sv
// Round-robin arbiter sharing one serialised AVMM fabric port between
// NUM_HOSTS masters; one transaction in flight, reads protected by a timeout.
module eth_f_hw_avmm_host_arb
  import eth_f_hw_avmm_pkg::*;
#(
  parameter int NUM_HOSTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DAT_WIDTH  = 32,
  parameter int TIMEOUT    = 8,
  parameter logic [DAT_WIDTH-1:0] TIMEOUT_DATA = DAT_WIDTH'(TIMEOUT_DATA_DEF),
  localparam int GW = idx_width(NUM_HOSTS)
) (
  input  logic                            clk,
  input  logic                            arst,
  input  logic [NUM_HOSTS*ADDR_WIDTH-1:0] host_address,
  input  logic [NUM_HOSTS-1:0]            host_read,
  input  logic [NUM_HOSTS-1:0]            host_write,
  input  logic [NUM_HOSTS*DAT_WIDTH-1:0]  host_writedata,
  output logic [NUM_HOSTS-1:0]            host_waitrequest,
  output logic [DAT_WIDTH-1:0]            host_readdata,
  output logic [NUM_HOSTS-1:0]            host_readdatavalid,
  output logic [ADDR_WIDTH-1:0]           fab_address,
  output logic                            fab_read,
  output logic                            fab_write,
  output logic [DAT_WIDTH-1:0]            fab_writedata,
  input  logic                            fab_waitrequest,
  input  logic [DAT_WIDTH-1:0]            fab_readdata,
  input  logic                            fab_readdatavalid,
  output logic [GW-1:0]                   grant_id,
  output logic [15:0]                     timeout_cnt
);

  state_t                 state;
  logic [GW-1:0]          rr_ptr;
  logic [NUM_HOSTS-1:0]   grant_oh;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic [DAT_WIDTH-1:0]   cmd_data;
  logic                   cmd_rd;
  logic [TIMEOUT-1:0]     timer;

  logic [NUM_HOSTS-1:0]   req;
  logic [NUM_HOSTS-1:0]   pick_grant;
  logic [GW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   accept;

  assign req = host_read | host_write;

  eth_f_hw_rr_pick #(
    .NUM_HOSTS (NUM_HOSTS)
  ) u_pick (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .valid     (pick_valid)
  );

  // Fabric strobes decode straight from state so an async reset drops them at once.
  assign accept           = (state == ST_CMD) && !fab_waitrequest;
  assign fab_read         = (state == ST_CMD) && cmd_rd;
  assign fab_write        = (state == ST_CMD) && !cmd_rd;
  assign fab_address      = cmd_addr;
  assign fab_writedata    = cmd_data;
  assign host_waitrequest = ~(grant_oh & {NUM_HOSTS{accept}});

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state              <= ST_IDLE;
      rr_ptr             <= '0;
      grant_id           <= '0;
      grant_oh           <= '0;
      cmd_addr           <= '0;
      cmd_data           <= '0;
      cmd_rd             <= 1'b0;
      timer              <= '0;
      host_readdata      <= '0;
      host_readdatavalid <= '0;
      timeout_cnt        <= '0;
    end else begin
      host_readdatavalid <= '0;
      case (state)
        ST_IDLE: begin
          // A read+write collision on one host resolves to the read.
          if (pick_valid) begin
            state    <= ST_CMD;
            grant_id <= pick_idx;
            grant_oh <= pick_grant;
            cmd_addr <= host_address[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            cmd_data <= host_writedata[pick_idx*DAT_WIDTH +: DAT_WIDTH];
            cmd_rd   <= host_read[pick_idx];
          end
        end
        ST_CMD: begin
          if (!fab_waitrequest) begin
            rr_ptr <= (grant_id == GW'(NUM_HOSTS-1)) ? '0 : grant_id + 1'b1;
            timer  <= '0;
            state  <= cmd_rd ? ST_RESP : ST_IDLE;
          end
        end
        ST_RESP: begin
          timer <= timer + 1'b1;
          // A real response beats a timeout expiring in the same cycle.
          if (fab_readdatavalid) begin
            host_readdata      <= fab_readdata;
            host_readdatavalid <= grant_oh;
            state              <= ST_IDLE;
          end else if (&timer) begin
            host_readdata      <= TIMEOUT_DATA;
            host_readdatavalid <= grant_oh;
            if (timeout_cnt != 16'hFFFF)
              timeout_cnt <= timeout_cnt + 16'd1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
